// File: rtl/jk_stim_checker.sv
// jk_stim_checker: drives pseudo-random J/K/EN vectors into an external JK flip-flop
// and checks its Q against an internal reference model two clock edges later.
module jk_stim_checker #(
  parameter int         NUM_VECTORS = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q_dut,
  output logic       j,
  output logic       k,
  output logic       en,
  output logic       ff_reset,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] vec_count
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS);

  state_t     state, state_next;
  logic       phase, phase_next;
  logic       j_next, k_next, en_next, ff_reset_next;
  logic       accept, drive_vec;
  logic [7:0] lfsr, lfsr_adv;
  logic       q_model, q_model_next;
  logic       vec_d1, vec_d2;
  logic       mismatch;

  // x^8+x^6+x^5+x^4+1, shifting toward bit 0 with feedback entering bit 7
  assign lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};

  assign busy     = (state == INIT) || (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign pass     = done && (err_count == 8'd0);
  assign mismatch = (q_dut !== q_model);

  always_comb begin
    q_model_next = q_model;
    if (ff_reset) begin
      q_model_next = 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q_model_next = 1'b0;
        2'b10:   q_model_next = 1'b1;
        2'b11:   q_model_next = ~q_model;
        default: q_model_next = q_model;
      endcase
    end
  end

  // INIT and DRAIN each use phase to count out their two cycles
  always_comb begin
    state_next    = state;
    phase_next    = 1'b0;
    j_next        = 1'b0;
    k_next        = 1'b0;
    en_next       = 1'b0;
    ff_reset_next = 1'b0;
    accept        = 1'b0;
    drive_vec     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept        = 1'b1;
          state_next    = INIT;
          ff_reset_next = 1'b1;
        end
      end
      INIT: begin
        if (phase) begin
          state_next = RUN;
          drive_vec  = 1'b1;
          j_next     = lfsr[0];
          k_next     = lfsr[1];
          en_next    = lfsr[2] | lfsr[3];
        end else begin
          phase_next    = 1'b1;
          ff_reset_next = 1'b1;
        end
      end
      RUN: begin
        if (vec_count == LAST_VEC) begin
          state_next = DRAIN;
        end else begin
          drive_vec = 1'b1;
          j_next    = lfsr[0];
          k_next    = lfsr[1];
          en_next   = lfsr[2] | lfsr[3];
        end
      end
      DRAIN: begin
        if (phase) begin
          state_next = DONE;
        end else begin
          phase_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      phase    <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      en       <= 1'b0;
      ff_reset <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      j        <= j_next;
      k        <= k_next;
      en       <= en_next;
      ff_reset <= ff_reset_next;
    end
  end

  // vec_d2 marks the edge at which the flop's response to a vector is checked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= LFSR_SEED;
      vec_count <= 8'd0;
      err_count <= 8'd0;
      q_model   <= 1'b0;
      vec_d1    <= 1'b0;
      vec_d2    <= 1'b0;
    end else begin
      vec_d1 <= drive_vec;
      vec_d2 <= vec_d1;
      if (accept) begin
        lfsr      <= LFSR_SEED;
        vec_count <= 8'd0;
        err_count <= 8'd0;
        q_model   <= 1'b0;
      end else begin
        q_model <= q_model_next;
        if (drive_vec) begin
          lfsr      <= lfsr_adv;
          vec_count <= vec_count + 8'd1;
        end
        if (vec_d2 && mismatch && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_stim_checker.sv
// Bench for jk_stim_checker: three instances (16, 255 and 1 vectors), each driving a
// bench-side JK flip-flop that behaves as golden, stuck-at-0 or inverted-Q.
module tb_jk_stim_checker;

  localparam int NV [3] = '{16, 255, 1};

  typedef struct {
    int inst;
    int mode;
    bit spurious;
    bit exp_pass;
    int exp_busy;
  } case_t;

  logic       clk = 1'b0;
  logic       rst_s   [3];
  logic       start_s [3];
  int         mode_s  [3];
  wire        q_s     [3];
  wire        j_s     [3];
  wire        k_s     [3];
  wire        en_s    [3];
  wire        ffr_s   [3];
  wire        busy_s  [3];
  wire        done_s  [3];
  wire        pass_s  [3];
  wire  [7:0] err_s   [3];
  wire  [7:0] vec_s   [3];

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_vec [256];
  int         exp_err;
  case_t      cases [8];

  always #5 clk = ~clk;

  jk_stim_checker #(.NUM_VECTORS(16), .LFSR_SEED(8'hA5)) dut0 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .q_dut(q_s[0]),
    .j(j_s[0]), .k(k_s[0]), .en(en_s[0]), .ff_reset(ffr_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err_s[0]), .vec_count(vec_s[0]));

  jk_stim_checker #(.NUM_VECTORS(255), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .q_dut(q_s[1]),
    .j(j_s[1]), .k(k_s[1]), .en(en_s[1]), .ff_reset(ffr_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err_s[1]), .vec_count(vec_s[1]));

  jk_stim_checker #(.NUM_VECTORS(1), .LFSR_SEED(8'hA5)) dut2 (
    .clk(clk), .reset(rst_s[2]), .start(start_s[2]), .q_dut(q_s[2]),
    .j(j_s[2]), .k(k_s[2]), .en(en_s[2]), .ff_reset(ffr_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .err_count(err_s[2]), .vec_count(vec_s[2]));

  // mode 0 = golden Q, 1 = stuck-at-0, 2 = inverted Q
  for (genvar g = 0; g < 3; g++) begin : g_ff
    logic q_ff = 1'b0;
    always @(posedge clk) begin
      if (ffr_s[g]) begin
        q_ff <= 1'b0;
      end else if (en_s[g]) begin
        case ({j_s[g], k_s[g]})
          2'b01:   q_ff <= 1'b0;
          2'b10:   q_ff <= 1'b1;
          2'b11:   q_ff <= ~q_ff;
          default: q_ff <= q_ff;
        endcase
      end
    end
    assign q_s[g] = (mode_s[g] == 1) ? 1'b0 : (mode_s[g] == 2) ? ~q_ff : q_ff;
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int   taps [4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= s[3'(8 - taps[t])];
    return {fb, s[7:1]};
  endfunction

  function automatic logic [13:0] obs(input int i);
    return {busy_s[i], done_s[i], ffr_s[i], en_s[i], k_s[i], j_s[i], vec_s[i]};
  endfunction

  function automatic logic [22:0] obs_all(input int i);
    return {busy_s[i], done_s[i], pass_s[i], ffr_s[i], en_s[i], k_s[i], j_s[i],
            err_s[i], vec_s[i]};
  endfunction

  // Expected vector list and error total straight from the LFSR and JK truth table
  task automatic buildModel(input int nv, input int mode);
    logic [7:0] s;
    logic       q;
    logic       seen;
    int         errs;
    s    = 8'hA5;
    q    = 1'b0;
    errs = 0;
    for (int i = 0; i < nv; i++) begin
      exp_vec[i] = {s[2] | s[3], s[1], s[0]};
      if (s[2] | s[3]) begin
        if (s[0] && s[1]) q = !q;
        else if (s[0])    q = 1'b1;
        else if (s[1])    q = 1'b0;
      end
      seen = (mode == 1) ? 1'b0 : (mode == 2) ? !q : q;
      if (seen != q) errs++;
      s = lfsr_next(s);
    end
    exp_err = (errs > 255) ? 255 : errs;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int inst, input int mode, input bit spurious,
                               input bit exp_pass, input int exp_busy);
    int         nv;
    int         busy_cycles;
    logic [13:0] exp_o;
    nv          = NV[inst];
    busy_cycles = 0;
    buildModel(nv, mode);
    mode_s[inst] = mode;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start_s[inst] = 1'b1;
    @(negedge clk);
    start_s[inst] = 1'b0;
    for (int c = 0; c < nv + 4; c++) begin
      if (c < 2)           exp_o = {3'b101, 3'b000, 8'd0};
      else if (c < nv + 2) exp_o = {3'b100, exp_vec[c-2], 8'(c - 1)};
      else                 exp_o = {3'b100, 3'b000, 8'(nv)};
      checkOutput($sformatf("trace dut%0d cycle%0d", inst, c), 32'(obs(inst)), 32'(exp_o));
      if (busy_s[inst]) busy_cycles++;
      if (spurious) start_s[inst] = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start_s[inst] = 1'b0;
    checkOutput($sformatf("done dut%0d", inst), 32'(done_s[inst]), 32'd1);
    checkOutput($sformatf("pass dut%0d", inst), 32'(pass_s[inst]), 32'(exp_pass));
    checkOutput($sformatf("err_count dut%0d", inst), 32'(err_s[inst]), 32'(exp_err));
    checkOutput($sformatf("vec_count dut%0d", inst), 32'(vec_s[inst]), 32'(nv));
    checkOutput($sformatf("busy_cycles dut%0d", inst), 32'(busy_cycles), 32'(exp_busy));
    repeat (2) @(negedge clk);
    checkOutput($sformatf("done_hold dut%0d", inst),
                32'({busy_s[inst], done_s[inst], err_s[inst], vec_s[inst]}),
                32'({1'b0, 1'b1, 8'(exp_err), 8'(nv)}));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cases[0] = '{0, 0, 1'b0, 1'b1, 20};
    cases[1] = '{0, 1, 1'b1, 1'b0, 20};
    cases[2] = '{0, 0, 1'b1, 1'b1, 20};
    cases[3] = '{1, 2, 1'b0, 1'b0, 259};
    cases[4] = '{2, 0, 1'b0, 1'b1, 5};
    cases[5] = '{2, 2, 1'b1, 1'b0, 5};
    cases[6] = '{1, 0, 1'b1, 1'b1, 259};
    cases[7] = '{2, 1, 1'b0, 1'b0, 5};

    for (int i = 0; i < 3; i++) begin
      rst_s[i]   = 1'b0;
      start_s[i] = 1'b0;
      mode_s[i]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset_state dut%0d", i), 32'(obs_all(i)), 32'd0);
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("post_release dut%0d", i), 32'(obs_all(i)), 32'd0);

    for (int i = 0; i < 8; i++)
      applyStimulus(cases[i].inst, cases[i].mode, cases[i].spurious,
                    cases[i].exp_pass, cases[i].exp_busy);

    for (int r = 0; r < 6; r++) begin
      int m;
      m = int'($urandom_range(0, 2));
      applyStimulus(0, m, bit'($urandom_range(0, 1)), (m == 0), 20);
    end

    // Abort a run at vector 5 with a one-cycle reset, then expect a clean rerun
    mode_s[0] = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("mid_run_vec_count", 32'(vec_s[0]), 32'd6);
    rst_s[0] = 1'b0;
    #1;
    checkOutput("mid_run_reset", 32'(obs_all(0)), 32'd0);
    @(negedge clk);
    rst_s[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_after_abort", 32'(obs_all(0)), 32'd0);
    end
    applyStimulus(0, 0, 1'b0, 1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
